// File: rtl/imem_port.sv
`default_nettype none
// ============================================================================
// Module      : imem_port
// Description : Instruction-memory responder. Serves 32-bit fetches from a
//               one-entry line buffer. On a miss it stalls the fetch stage and
//               assembles the word from two 16-bit req/ack reads, low half
//               first.
//               Optional ack watchdog enabled by defining IMEM_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_port #(
    parameter int         ADDR       = 16,
    parameter int         WORD       = 32,
    parameter logic [7:0] TMO_CYCLES = 8'd64
) (
    input  logic            clk,
    input  logic            rst,          // asynchronous, active low
    input  logic [ADDR-1:0] inst_addr_i,
    output logic [WORD-1:0] inst_o,
    output logic            stall_o,
    output logic            mem_req_o,
    output logic [ADDR:0]   mem_addr_o,
    input  logic            mem_ack_i,
    input  logic [15:0]     mem_data_i,
    output logic            err_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RD_LO = 2'd1,
        S_RD_HI = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_buf_valid;
    logic [ADDR-1:0] r_buf_tag;
    logic [WORD-1:0] r_buf_data;
    logic [ADDR-1:0] r_req_addr;
    logic [15:0]     r_lo;
    logic            r_mem_req;
    logic [ADDR:0]   r_mem_addr;
    logic            w_hit;
    logic            w_tmo;

    // Hit is purely combinational so a buffered word costs no latency.
    assign w_hit      = r_buf_valid && (r_buf_tag == inst_addr_i);
    assign stall_o    = ~w_hit;
    // A miss hands the fetch stage an all-zero NOP bubble.
    assign inst_o     = w_hit ? r_buf_data : '0;
    assign mem_req_o  = r_mem_req;
    assign mem_addr_o = r_mem_addr;

`ifdef IMEM_TIMEOUT_EN
    logic [7:0] r_tmo_cnt;
    logic       r_err;

    // Ack watchdog: counts unacknowledged request cycles, error flag is sticky.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tmo_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            if (r_state == S_IDLE || mem_ack_i) begin
                r_tmo_cnt <= '0;
            end else if (r_mem_req) begin
                r_tmo_cnt <= r_tmo_cnt + 8'd1;
            end
            if (w_tmo) begin
                r_err <= 1'b1;
            end
        end
    end

    // Fires in the last allowed wait cycle so the request lasts TMO_CYCLES.
    assign w_tmo = r_mem_req && !mem_ack_i && (r_tmo_cnt == TMO_CYCLES - 8'd1);
    assign err_o = r_err;
`else
    logic w_unused_tmo;

    assign w_tmo        = 1'b0;
    assign err_o        = 1'b0;
    assign w_unused_tmo = ^TMO_CYCLES;
`endif

    // Fill sequencer: owns the line buffer and the registered memory request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_req_addr  <= '0;
            r_lo        <= '0;
            r_buf_valid <= 1'b0;
            r_buf_tag   <= '0;
            r_buf_data  <= '0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Old word stays valid during the fill so a jump back hits.
                    if (!w_hit) begin
                        r_req_addr <= inst_addr_i;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= {inst_addr_i, 1'b0};
                        r_state    <= S_RD_LO;
                    end
                end
                S_RD_LO: begin
                    if (mem_ack_i) begin
                        r_lo       <= mem_data_i;
                        // Request stays high; only the halfword select flips.
                        r_mem_addr <= {r_req_addr, 1'b1};
                        r_state    <= S_RD_HI;
                    end else if (w_tmo) begin
                        r_buf_data  <= '0;
                        r_buf_tag   <= r_req_addr;
                        r_buf_valid <= 1'b1;
                        r_mem_req   <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                S_RD_HI: begin
                    if (mem_ack_i) begin
                        r_buf_data  <= {mem_data_i, r_lo};
                        r_buf_tag   <= r_req_addr;
                        r_buf_valid <= 1'b1;
                        r_mem_req   <= 1'b0;
                        r_state     <= S_IDLE;
                    end else if (w_tmo) begin
                        r_buf_data  <= '0;
                        r_buf_tag   <= r_req_addr;
                        r_buf_valid <= 1'b1;
                        r_mem_req   <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_port
// Description : Self-checking bench for imem_port. A wait-state memory
//               responder, a cycle-level behavioural model compared every
//               cycle, and directed scenarios with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_port;

    localparam int         c_addr = 16;
    localparam int         c_word = 32;
    localparam logic [7:0] c_tmo  = 8'd64;

    logic              clk;
    logic              rst;
    logic [c_addr-1:0] inst_addr_i;
    logic [c_word-1:0] inst_o;
    logic              stall_o;
    logic              mem_req_o;
    logic [c_addr:0]   mem_addr_o;
    logic              mem_ack_i;
    logic [15:0]       mem_data_i;
    logic              err_o;

    imem_port #(
        .ADDR       (c_addr),
        .WORD       (c_word),
        .TMO_CYCLES (c_tmo)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .inst_addr_i (inst_addr_i),
        .inst_o      (inst_o),
        .stall_o     (stall_o),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_ack_i   (mem_ack_i),
        .mem_data_i  (mem_data_i),
        .err_o       (err_o)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Responder configuration, changed only while no fill is in flight.
    int   wait_n    = 0;
    logic never_ack = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Contents of the external halfword memory.
    function automatic logic [15:0] mem_hw(input logic [16:0] a);
        if (a == 17'h0)      return 16'h5678;
        else if (a == 17'h1) return 16'h1234;
        else                 return a[15:0] ^ 16'hC3A5;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Memory responder: each halfword is acked after wait_n extra cycles.
    int   rsp_waited = 0;
    logic rsp_pend   = 1'b0;
    always @(posedge clk) begin
        #1;
        if (!mem_req_o) begin
            rsp_pend  = 1'b0;
            mem_ack_i = 1'b0;
        end else begin
            if (!rsp_pend) begin
                rsp_pend   = 1'b1;
                rsp_waited = 0;
            end else begin
                rsp_waited++;
            end
            if (!never_ack && rsp_waited >= wait_n) begin
                mem_ack_i  = 1'b1;
                mem_data_i = mem_hw(mem_addr_o);
                rsp_pend   = 1'b0;
            end else begin
                mem_ack_i  = 1'b0;
                mem_data_i = 16'hDEAD;
            end
        end
    end

    // Behavioural model: buffer contents plus a fill that takes a known
    // number of request cycles, derived from the responder's wait states.
    logic              m_valid = 1'b0;
    logic [c_addr-1:0] m_tag   = '0;
    logic [31:0]       m_data  = '0;
    logic              m_busy  = 1'b0;
    logic [c_addr-1:0] m_fill  = '0;
    int                m_k     = 0;
    logic [c_addr:0]   m_last  = '0;
    logic              m_err   = 1'b0;
    logic              e_hit;
    logic [c_addr:0]   e_addr;

    always @(negedge clk) begin
        if (!rst) begin
            m_valid = 1'b0; m_tag = '0; m_data = '0; m_busy = 1'b0;
            m_k = 0; m_last = '0; m_err = 1'b0;
        end
        e_hit  = m_valid && (m_tag == inst_addr_i);
        e_addr = m_busy ? {m_fill, (!never_ack && m_k > wait_n)} : m_last;
        m_last = e_addr;
        check("model_stall", 64'(stall_o),    64'(!e_hit));
        check("model_inst",  64'(inst_o),     64'(e_hit ? m_data : 32'h0));
        check("model_req",   64'(mem_req_o),  64'(m_busy));
        check("model_addr",  64'(mem_addr_o), 64'(e_addr));
        check("model_err",   64'(err_o),      64'(m_err));
        if (rst) begin
            if (m_busy) begin
`ifdef IMEM_TIMEOUT_EN
                if (never_ack && m_k == int'(c_tmo) - 1) begin
                    m_data = 32'h0; m_tag = m_fill; m_valid = 1'b1;
                    m_busy = 1'b0; m_err = 1'b1;
                end else
`endif
                if (!never_ack && m_k == 2 * wait_n + 1) begin
                    m_data  = {mem_hw({m_fill, 1'b1}), mem_hw({m_fill, 1'b0})};
                    m_tag   = m_fill;
                    m_valid = 1'b1;
                    m_busy  = 1'b0;
                end else begin
                    m_k++;
                end
            end else if (!e_hit) begin
                m_busy = 1'b1;
                m_fill = inst_addr_i;
                m_k    = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic        exp_stall [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] exp_inst  [4] = '{32'h0, 32'h0, 32'h0, 32'h1234_5678};
    logic [16:0] exp_maddr [4] = '{17'h0, 17'h0, 17'h1, 17'h1};
    int          n_stall;
    int          n_req;

    initial begin
        rst         = 1'b0;
        inst_addr_i = 16'h0000;
        mem_ack_i   = 1'b0;
        mem_data_i  = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_stall", 64'(stall_o), 64'd1);
        check("reset_inst",  64'(inst_o),  64'd0);
        check("reset_req",   64'(mem_req_o), 64'd0);

        // First fetch from address 0 with a zero-wait memory.
        next_cycle();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("first_stall", 64'(stall_o), 64'(exp_stall[i]));
            check("first_inst",  64'(inst_o),  64'(exp_inst[i]));
            if (i == 1 || i == 2) begin
                check("first_req",  64'(mem_req_o),  64'd1);
                check("first_addr", 64'(mem_addr_o), 64'(exp_maddr[i]));
            end
        end

        // Two wait states per halfword.
        next_cycle();
        wait_n      = 2;
        inst_addr_i = 16'h0010;
        n_stall = 0;
        n_req   = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (!stall_o) break;
            n_stall++;
            if (mem_req_o) begin
                check("wait_addr", 64'(mem_addr_o), 64'(n_req < 3 ? 17'h00020 : 17'h00021));
                n_req++;
            end else if (n_req != 0) begin
                check("wait_req_gap", 64'(mem_req_o), 64'd1);
            end
        end
        check("wait_stall_cycles", 64'(n_stall), 64'd7);
        check("wait_req_cycles",   64'(n_req),   64'd6);
        check("wait_inst",         64'(inst_o),  64'h0000_0000_C384_C385);

        // Repeated hits must not touch the memory.
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("hit_stall", 64'(stall_o),   64'd0);
            check("hit_req",   64'(mem_req_o), 64'd0);
        end

        // Address change while the high half is being read.
        next_cycle();
        wait_n      = 0;
        inst_addr_i = 16'h0020;
        next_cycle();
        next_cycle();
        inst_addr_i = 16'h0030;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("switch_req",  64'(mem_req_o),  64'd1);
        check("switch_addr", 64'(mem_addr_o), 64'h60);
        next_cycle();
        inst_addr_i = 16'h0020;
        @(negedge clk);
        check("switch_back_stall", 64'(stall_o), 64'd0);
        check("switch_back_inst",  64'(inst_o),  64'h0000_0000_C3E4_C3E5);
        next_cycle();
        @(negedge clk);
        check("switch_idle_req", 64'(mem_req_o), 64'd0);

        // Reset while the low half is outstanding.
        next_cycle();
        wait_n      = 3;
        inst_addr_i = 16'h0040;
        next_cycle();
        #2;
        check("midrst_req_before", 64'(mem_req_o), 64'd1);
        rst = 1'b0;
        #1;
        check("midrst_req_drop", 64'(mem_req_o), 64'd0);
        inst_addr_i = 16'h0030;
        #1;
        check("midrst_buf_invalid", 64'(stall_o), 64'd1);
        check("midrst_inst",        64'(inst_o),  64'd0);
        next_cycle();
        next_cycle();
        wait_n = 0;
        rst    = 1'b1;
        @(negedge clk);
        check("restart_idle_req", 64'(mem_req_o), 64'd0);
        @(negedge clk);
        check("restart_req",  64'(mem_req_o),  64'd1);
        check("restart_addr", 64'(mem_addr_o), 64'h60);
        repeat (3) @(negedge clk);
        check("restart_inst", 64'(inst_o), 64'h0000_0000_C3C4_C3C5);

`ifdef IMEM_TIMEOUT_EN
        // Memory that never acknowledges.
        next_cycle();
        never_ack   = 1'b1;
        inst_addr_i = 16'h0050;
        n_req = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (mem_req_o) n_req++;
            if (!stall_o) break;
        end
        check("tmo_req_cycles", 64'(n_req),   64'd64);
        check("tmo_err",        64'(err_o),   64'd1);
        check("tmo_stall",      64'(stall_o), 64'd0);
        check("tmo_inst",       64'(inst_o),  64'd0);
        next_cycle();
        never_ack   = 1'b0;
        inst_addr_i = 16'h0030;
        repeat (5) @(negedge clk);
        check("tmo_err_sticky", 64'(err_o),  64'd1);
        check("tmo_refill",     64'(inst_o), 64'h0000_0000_C3C4_C3C5);
`endif

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
